proc_ctrl_seq: RTL and testbench

Multi-cycle control sequencer for the 8-bit simple processor datapath (register file of 8x8, 2-bit ALU, 8-bit PC). Fetches one 8-bit instruction per iteration over a req/ack instruction-memory handshake, then decodes it. Drives register-file addresses, alu_op and reg_write, and owns the PC. Adds run/halt, single-step debug and fetch-timeout fault handling for the Tiny Tapeout top level.

---
 rtl/proc_ctrl_pkg.sv | 29 ++
 rtl/proc_ctrl_decode.sv | 39 +++
 rtl/proc_ctrl_seq.sv | 160 ++++++++++++++++
 tb/tb_proc_ctrl_seq.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared types and instruction-field constants for the processor control sequencer.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  localparam logic [2:0] SYS_NOP  = 3'b000;
  localparam logic [2:0] SYS_HALT = 3'b001;
  localparam logic [2:0] SYS_BZ   = 3'b010;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int RT_MSB  = 2;
  localparam int RT_LSB  = 0;

endpackage

// File: rtl/proc_ctrl_decode.sv
// Combinational instruction decode: ALU function, system sub-op flags and the
// sign-extended branch offset, all derived from the instruction register.
module proc_ctrl_decode #(
  parameter int PC_W = 8
) (
  input  logic [7:0]      ir_i,
  output logic [1:0]      alu_op_o,
  output logic            is_alu_o,
  output logic            is_halt_o,
  output logic            is_bz_o,
  output logic [PC_W-1:0] br_off_o
);
  import proc_ctrl_pkg::*;

  always_comb begin
    alu_op_o  = '0;
    is_alu_o  = 1'b0;
    is_halt_o = 1'b0;
    is_bz_o   = 1'b0;
    case (ir_i[OPC_MSB:OPC_LSB])
      OP_ADD, OP_SUB, OP_AND: begin
        is_alu_o = 1'b1;
        alu_op_o = ir_i[OPC_MSB:OPC_LSB];
      end
      OP_SYS: begin
        case (ir_i[RD_MSB:RD_LSB])
          SYS_HALT: is_halt_o = 1'b1;
          SYS_BZ:   is_bz_o   = 1'b1;
          SYS_NOP:  ;
          default:  ;
        endcase
      end
      default: ;
    endcase
  end

  assign br_off_o = {{(PC_W-3){ir_i[RT_MSB]}}, ir_i[RT_MSB:RT_LSB]};

endmodule

// File: rtl/proc_ctrl_seq.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with run/halt, single-step
// and fetch-timeout fault handling. Owns the PC and instruction register.
//
// state  | meaning
// IDLE   | waiting for run_en (and step_req when step_mode=1)
// FETCH  | imem_req high, waiting for imem_ack; timeout -> fault
// DECODE | register-file addresses captured from IR
// EXEC   | ALU operates; zero flag captured for ALU ops
// WB     | reg_write for ALU ops, PC advance or branch
// HALT   | stopped; resume returns to IDLE unless faulted
module proc_ctrl_seq #(
  parameter int              PC_W          = 8,
  parameter logic [PC_W-1:0] PC_RESET      = '0,
  parameter int              FETCH_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_en,
  input  logic            step_mode,
  input  logic            step_req,
  input  logic            resume,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  input  logic            alu_zero,
  output logic [2:0]      rs,
  output logic [2:0]      rt,
  output logic [2:0]      rd,
  output logic [1:0]      alu_op,
  output logic            reg_write,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            fault,
  output logic            busy
);
  import proc_ctrl_pkg::*;

  localparam logic [7:0] TO_LOAD = 8'(FETCH_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [2:0]      rsd_q, rsd_d;
  logic [2:0]      rt_q, rt_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic            zero_q, zero_d;
  logic            fault_q, fault_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [1:0]      dec_alu_op;
  logic            dec_is_alu;
  logic            dec_is_halt;
  logic            dec_is_bz;
  logic [PC_W-1:0] dec_off;

  proc_ctrl_decode #(.PC_W(PC_W)) u_dec (
    .ir_i      (ir_q),
    .alu_op_o  (dec_alu_op),
    .is_alu_o  (dec_is_alu),
    .is_halt_o (dec_is_halt),
    .is_bz_o   (dec_is_bz),
    .br_off_o  (dec_off)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      rsd_q    <= '0;
      rt_q     <= '0;
      alu_op_q <= '0;
      zero_q   <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      rsd_q    <= rsd_d;
      rt_q     <= rt_d;
      alu_op_q <= alu_op_d;
      zero_q   <= zero_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    rsd_d    = rsd_q;
    rt_d     = rt_q;
    alu_op_d = alu_op_q;
    zero_d   = zero_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (run_en && (!step_mode || step_req)) begin
          state_d = ST_FETCH;
          cnt_d   = TO_LOAD;
        end
      end
      ST_FETCH: begin
        // Down-counter reaches zero on the FETCH_TIMEOUT-th cycle without ack.
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end else if (cnt_q == '0) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DECODE: begin
        rsd_d    = ir_q[RD_MSB:RD_LSB];
        rt_d     = ir_q[RT_MSB:RT_LSB];
        alu_op_d = dec_is_alu ? dec_alu_op : '0;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_is_alu) zero_d = alu_zero;
        state_d = ST_WB;
      end
      ST_WB: begin
        if (dec_is_bz && zero_q) pc_d = pc_q + PC_W'(1) + dec_off;
        else                     pc_d = pc_q + PC_W'(1);
        if (dec_is_halt) begin
          state_d = ST_HALT;
        end else if (run_en && !step_mode) begin
          state_d = ST_FETCH;
          cnt_d   = TO_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (resume && !fault_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign reg_write = (state_q == ST_WB) && dec_is_alu;
  assign rs        = rsd_q;
  assign rd        = rsd_q;
  assign rt        = rt_q;
  assign alu_op    = alu_op_q;
  assign pc        = pc_q;
  assign halted    = (state_q == ST_HALT);
  assign fault     = fault_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);

endmodule

// File: tb/tb_proc_ctrl_seq.sv
// Directed plus randomized bench for proc_ctrl_seq against an instruction-level
// model of the architectural state (pc, zero flag, halted, fault).
module tb_proc_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_en = 1'b0, step_mode = 1'b0, step_req = 1'b0, resume = 1'b0;
  logic       imem_req, imem_ack = 1'b0;
  logic [7:0] imem_addr, imem_rdata = 8'h00;
  logic       alu_zero = 1'b0;
  logic [2:0] rs, rt, rd;
  logic [1:0] alu_op;
  logic       reg_write;
  logic [7:0] pc;
  logic       halted, fault, busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [256];
  int         m_pc = 0;
  bit         m_zero = 1'b0;
  bit         m_halted = 1'b0;
  bit         step_in_fetch = 1'b0;
  bit         cont;

  proc_ctrl_seq dut (
    .clk        (clk),
    .rst        (rst),
    .run_en     (run_en),
    .step_mode  (step_mode),
    .step_req   (step_req),
    .resume     (resume),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .alu_zero   (alu_zero),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .pc         (pc),
    .halted     (halted),
    .fault      (fault),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_zero = 1'b0;
    m_halted = 1'b0;
  endtask

  // Runs one instruction starting in its first FETCH cycle; wt = cycles before ack.
  task automatic exec_one(input int wt, input bit zin, output bit go_on);
    logic [7:0] ins;
    int op, f, t, off;
    bit is_alu, is_halt, is_bz;
    ins     = mem[m_pc];
    op      = int'(ins[7:6]);
    f       = int'(ins[5:3]);
    t       = int'(ins[2:0]);
    is_alu  = (op != 3);
    is_halt = (op == 3) && (f == 1);
    is_bz   = (op == 3) && (f == 2);
    for (int k = 0; k <= wt; k++) begin
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, m_pc);
      chk("fetch_wr", reg_write, 0);
      step_req = step_in_fetch && (k == 0);
      if (k == wt) begin
        imem_ack = 1'b1;
        imem_rdata = ins;
      end else begin
        imem_ack = 1'b0;
        imem_rdata = 8'($urandom);
      end
      tick();
    end
    imem_ack = 1'b0;
    step_req = 1'b0;
    chk("decode_req", imem_req, 0);
    chk("decode_wr", reg_write, 0);
    chk("decode_busy", busy, 1);
    tick();
    chk("exec_rd", rd, f);
    chk("exec_rs", rs, f);
    chk("exec_rt", rt, t);
    chk("exec_wr", reg_write, 0);
    if (is_alu) chk("exec_aluop", alu_op, op);
    alu_zero = zin;
    tick();
    alu_zero = 1'($urandom);
    chk("wb_wr", reg_write, is_alu);
    chk("wb_rd", rd, f);
    chk("wb_pc", pc, m_pc);
    if (is_alu) chk("wb_aluop", alu_op, op);
    go_on = !is_halt && run_en && !step_mode;
    tick();
    off = (t >= 4) ? t - 8 : t;
    if (is_bz && m_zero) m_pc = (m_pc + 1 + off + 256) % 256;
    else                 m_pc = (m_pc + 1) % 256;
    if (is_alu) m_zero = zin;
    if (is_halt) m_halted = 1'b1;
    chk("post_pc", pc, m_pc);
    chk("post_halted", halted, m_halted);
    chk("post_req", imem_req, go_on);
    chk("post_busy", busy, go_on);
    chk("post_wr", reg_write, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
    tick();
    tick();
    chk("rst_pc", pc, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_wr", reg_write, 0);
    chk("rst_rd", rd, 0);
    chk("rst_rt", rt, 0);
    chk("rst_aluop", alu_op, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    model_reset();

    // ADD r1,r2 ; SUB r3,r3 ; HALT with zero-wait ack
    mem[0] = 8'b00_001_010;
    mem[1] = 8'b01_011_011;
    mem[2] = 8'b11_001_000;
    run_en = 1'b1;
    tick();
    exec_one(0, 1'b0, cont);
    exec_one(0, 1'b1, cont);
    exec_one(0, 1'b0, cont);
    chk("prog1_halted", halted, 1);
    chk("prog1_pc", pc, 3);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    m_halted = 1'b0;
    chk("resume_halted", halted, 0);
    chk("resume_busy", busy, 0);
    chk("resume_pc", pc, 3);

    // BZ taken / not taken, delayed ack on one ALU op and the final HALT
    mem[3] = 8'b01_011_011;
    mem[4] = 8'b00_001_010;
    mem[5] = 8'b11_010_110;
    mem[6] = 8'b11_001_000;
    tick();
    exec_one(0, 1'b1, cont);
    exec_one(0, 1'b1, cont);
    exec_one(0, 1'b0, cont);
    chk("bz_taken_pc", pc, 4);
    exec_one(3, 1'b0, cont);
    exec_one(0, 1'b0, cont);
    chk("bz_not_taken_pc", pc, 6);
    exec_one(3, 1'b0, cont);
    chk("halt2_pc", pc, 7);
    resume = 1'b1;
    run_en = 1'b0;
    tick();
    resume = 1'b0;
    m_halted = 1'b0;

    // single-step: one instruction per step_req, step_req in FETCH ignored
    mem[7] = 8'b00_101_110;
    mem[8] = 8'b10_010_001;
    step_mode = 1'b1;
    run_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("step_wait_busy", busy, 0);
      tick();
    end
    step_in_fetch = 1'b1;
    for (int s = 0; s < 2; s++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      exec_one(2, 1'b0, cont);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("step_idle_busy", busy, 0);
        chk("step_idle_pc", pc, m_pc);
      end
    end
    step_in_fetch = 1'b0;

    // reset during EXEC: no write, pc back to 0 at once
    mem[9] = 8'b00_111_001;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("pre_rst_req", imem_req, 1);
    chk("pre_rst_addr", imem_addr, 9);
    imem_ack = 1'b1;
    imem_rdata = mem[9];
    tick();
    imem_ack = 1'b0;
    tick();
    chk("exec_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_exec_wr", reg_write, 0);
    chk("rst_exec_pc", pc, 0);
    chk("rst_exec_busy", busy, 0);
    tick();
    chk("rst_exec_wr2", reg_write, 0);
    rst = 1'b0;
    model_reset();

    // reset during FETCH drops imem_req asynchronously
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("fetch_before_rst", imem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_fetch_req", imem_req, 0);
    tick();
    rst = 1'b0;
    model_reset();

    // PC wrap both ways: 1+1-3 -> 255, then NOP at 255 -> 0; run_en drops mid-instruction
    mem[0]   = 8'b01_011_011;
    mem[1]   = 8'b11_010_101;
    mem[255] = 8'b11_000_000;
    step_mode = 1'b0;
    tick();
    exec_one(0, 1'b1, cont);
    exec_one(0, 1'b0, cont);
    chk("wrap_back_pc", pc, 255);
    run_en = 1'b0;
    exec_one(1, 1'b0, cont);
    chk("wrap_fwd_pc", pc, 0);
    chk("runen_off_idle", busy, 0);

    // fetch timeout: 15 FETCH cycles without ack -> fault + halt, resume ignored
    run_en = 1'b1;
    tick();
    for (int k = 0; k < 15; k++) begin
      chk("to_req", imem_req, 1);
      chk("to_fault_early", fault, 0);
      tick();
    end
    chk("to_fault", fault, 1);
    chk("to_halted", halted, 1);
    chk("to_req_drop", imem_req, 0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    tick();
    chk("to_resume_ignored", halted, 1);
    chk("to_fault_sticky", fault, 1);
    rst = 1'b1;
    #1;
    chk("to_rst_fault", fault, 0);
    chk("to_rst_halted", halted, 0);
    tick();
    rst = 1'b0;
    model_reset();

    // random program, random ack latency, random alu_zero, occasional run_en drop
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    run_en = 1'b1;
    tick();
    for (int n = 0; n < 80; n++) begin
      run_en = ($urandom_range(7) != 0);
      exec_one(int'($urandom_range(4)), 1'($urandom), cont);
      if (m_halted) begin
        resume = 1'b1;
        tick();
        resume = 1'b0;
        m_halted = 1'b0;
        chk("rnd_resume", halted, 0);
        run_en = 1'b1;
        tick();
      end else if (!cont) begin
        chk("rnd_idle_busy", busy, 0);
        run_en = 1'b1;
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
